// File: rtl/des_pkg.sv
// Shared DES constants: FIPS 46-3 permutation/expansion tables, S-boxes, key rotation
// schedule and the engine state type. Table entries are FIPS bit numbers (1 = MSB).
package des_pkg;

  typedef enum logic {IDLE, RUN} des_state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each box is 4 rows x 16 columns, flattened as row*16 + column.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Bit n-1 set: round n rotates C/D by one (rounds 1, 2, 9, 16); otherwise by two.
  localparam logic [15:0] ROT_ONE = 16'b1000_0001_0000_0011;

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  // Outer bits (b1, b6) select the row, inner four bits the column.
  function automatic logic [3:0] sbox(input int unsigned idx, input logic [5:0] b);
    return SBOX[idx][{b[5], b[0], b[4:1]}];
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K) = P(S1..S8(E(R) ^ K)); purely combinational.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f_out
);

  logic [47:0] x;
  logic [31:0] s_out;

  always_comb begin
    x     = e_exp(r) ^ k;
    s_out = '0;
    for (int unsigned i = 0; i < 8; i++) s_out[31-4*i -: 4] = sbox(i, x[47-6*i -: 6]);
    f_out = p_perm(s_out);
  end

endmodule

// File: rtl/des_top.sv
// Iterative DES encryption engine: one Feistel round per clock, start/done handshake,
// 17 cycles per block including the load edge.
module des_top
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] plain_text,
  input  logic [63:0] cipher_key,
  output logic [63:0] cipher_text,
  output logic        busy,
  output logic        done
);

  des_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] ct_q, ct_d;
  logic        done_q, done_d;

  logic        rot_one;
  logic [27:0] c_rot, d_rot;
  logic [47:0] k_n;
  logic [31:0] f_out;

  // cnt_q holds the number of completed rounds, so round n uses cnt_q = n-1.
  always_comb begin
    rot_one = ROT_ONE[cnt_q];
    c_rot   = rotl28(c_q, rot_one);
    d_rot   = rotl28(d_q, rot_one);
    k_n     = pc2_perm({c_rot, d_rot});
  end

  des_f u_f (
    .r     (r_q),
    .k     (k_n),
    .f_out (f_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          {l_d, r_d} = ip_perm(plain_text);
          {c_d, d_d} = pc1_perm(cipher_key);
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        c_d   = c_rot;
        d_d   = d_rot;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Final round: output is FP of the swapped halves {R16, L16}.
          ct_d    = fp_perm({l_q ^ f_out, r_q});
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign cipher_text = ct_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_des_top.sv
// Self-checking bench for des_top: known-answer vectors plus random vectors against a
// bit-array software DES model, with handshake, latency and reset scenarios.
module tb_des_top;
  import des_pkg::*;

  logic        clk, rst, start;
  logic [63:0] plain_text, cipher_key, cipher_text;
  logic        busy, done;

  int checks = 0;
  int passes = 0;
  int overlap_cnt = 0;

  des_top dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .plain_text  (plain_text),
    .cipher_key  (cipher_key),
    .cipher_text (cipher_text),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_cnt++;

  // Software DES over 1-based bit arrays: full key schedule first, then 16 rounds.
  function automatic logic [63:0] ref_des(input logic [63:0] pt, input logic [63:0] key);
    bit kb[1:64], pb[1:64], cd[1:56], l[1:32], r[1:32], nr[1:32], sb[1:32], pre[1:64];
    bit ex[1:48];
    bit ks[1:16][1:48];
    bit tc, td;
    int sh, row, col;
    logic [3:0] v;
    logic [63:0] res;
    for (int i = 1; i <= 64; i++) begin kb[i] = key[64-i]; pb[i] = pt[64-i]; end
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1_T[i-1]];
    for (int n = 1; n <= 16; n++) begin
      sh = (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        tc = cd[1]; td = cd[29];
        for (int j = 1; j < 28; j++) begin cd[j] = cd[j+1]; cd[28+j] = cd[29+j]; end
        cd[28] = tc; cd[56] = td;
      end
      for (int j = 1; j <= 48; j++) ks[n][j] = cd[PC2_T[j-1]];
    end
    for (int i = 1; i <= 32; i++) begin l[i] = pb[IP_T[i-1]]; r[i] = pb[IP_T[i+31]]; end
    for (int n = 1; n <= 16; n++) begin
      for (int j = 1; j <= 48; j++) ex[j] = r[E_T[j-1]] ^ ks[n][j];
      for (int s = 0; s < 8; s++) begin
        row = 2 * ex[6*s+1] + ex[6*s+6];
        col = 8 * ex[6*s+2] + 4 * ex[6*s+3] + 2 * ex[6*s+4] + ex[6*s+5];
        v = SBOX[s][row*16+col];
        sb[4*s+1] = v[3]; sb[4*s+2] = v[2]; sb[4*s+3] = v[1]; sb[4*s+4] = v[0];
      end
      for (int j = 1; j <= 32; j++) nr[j] = l[j] ^ sb[P_T[j-1]];
      l = r;
      r = nr;
    end
    for (int i = 1; i <= 32; i++) begin pre[i] = r[i]; pre[32+i] = l[i]; end
    res = '0;
    for (int i = 1; i <= 64; i++) res[64-i] = pre[FP_T[i-1]];
    return res;
  endfunction

  // One-cycle start pulse; lat counts edges from the load edge to the done edge inclusive.
  task automatic run_block(input logic [63:0] pt, input logic [63:0] key,
                           output logic [63:0] ct, output int lat);
    @(negedge clk);
    plain_text = pt; cipher_key = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    ct = cipher_text;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    int ndone;
    rst = 1'b0; start = 1'b0; plain_text = '0; cipher_key = '0;
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (cipher_text !== 64'h0) $display("FAIL reset_ct: got %h want 0", cipher_text); else passes++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); plain_text = 64'h0123456789ABCDEF; cipher_key = 64'h133457799BBCDFF1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL run_busy: got %b want 1", busy); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL async_rst_done: got %b want 0", done); else passes++;
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (done) ndone++; end
    checks++; if (ndone !== 0) $display("FAIL post_reset_done: got %0d pulses want 0", ndone); else passes++;
  endtask

  task automatic test_kat();
    logic [63:0] ct;
    int lat;
    run_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, ct, lat);
    checks++; if (ct !== 64'h85E813540F0AB405) $display("FAIL kat1_ct: got %h want 85e813540f0ab405", ct); else passes++;
    checks++; if (lat !== 17) $display("FAIL kat1_lat: got %0d want 17", lat); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL kat1_busy_at_done: got %b want 0", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL kat1_done_width: got %b want 0", done); else passes++;
    checks++; if (cipher_text !== 64'h85E813540F0AB405) $display("FAIL kat1_hold: got %h want 85e813540f0ab405", cipher_text); else passes++;
    run_block(64'h0, 64'h0, ct, lat);
    checks++; if (ct !== 64'h8CA64DE9C1B123A7) $display("FAIL kat_zero_ct: got %h want 8ca64de9c1b123a7", ct); else passes++;
    checks++; if (lat !== 17) $display("FAIL kat_zero_lat: got %0d want 17", lat); else passes++;
    run_block(64'h0123456789ABCDEF, 64'h0, ct, lat);
    checks++; if (ct !== ref_des(64'h0123456789ABCDEF, 64'h0)) $display("FAIL kat_key0_ct: got %h want %h", ct, ref_des(64'h0123456789ABCDEF, 64'h0)); else passes++;
    run_block(64'h4E6F772069732074, 64'h0123456789ABCDEF, ct, lat);
    checks++; if (ct !== 64'h3FA40E8A984D4815) $display("FAIL kat_now_ct: got %h want 3fa40e8a984d4815", ct); else passes++;
  endtask

  task automatic test_parity();
    logic [63:0] ct;
    int lat;
    run_block(64'h4E6F772069732074, 64'h0123456789ABCDEF ^ 64'h0101010101010101, ct, lat);
    checks++; if (ct !== 64'h3FA40E8A984D4815) $display("FAIL parity_ct: got %h want 3fa40e8a984d4815", ct); else passes++;
    checks++; if (lat !== 17) $display("FAIL parity_lat: got %0d want 17", lat); else passes++;
  endtask

  task automatic test_busy_ignore();
    logic [63:0] a_pt, a_key, got;
    int ndone, lat;
    a_pt = {$urandom, $urandom}; a_key = {$urandom, $urandom};
    @(negedge clk); plain_text = a_pt; cipher_key = a_key; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); plain_text = {$urandom, $urandom}; cipher_key = {$urandom, $urandom}; start = 1'b1;
    @(negedge clk); start = 1'b0; plain_text = ~plain_text;
    ndone = 0; got = '0; lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; got = cipher_text; if (lat < 0) lat = c + 6; end
    end
    checks++; if (ndone !== 1) $display("FAIL busy_ignore_pulses: got %0d want 1", ndone); else passes++;
    checks++; if (got !== ref_des(a_pt, a_key)) $display("FAIL busy_ignore_ct: got %h want %h", got, ref_des(a_pt, a_key)); else passes++;
    checks++; if (lat !== 17) $display("FAIL busy_ignore_lat: got %0d want 17", lat); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] ct, pt, key;
    int ndone, lat;
    @(negedge clk); plain_text = {$urandom, $urandom}; cipher_key = {$urandom, $urandom}; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passes++;
    checks++; if (cipher_text !== 64'h0) $display("FAIL mid_rst_ct: got %h want 0", cipher_text); else passes++;
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (done) ndone++; end
    checks++; if (ndone !== 0) $display("FAIL mid_rst_done: got %0d pulses want 0", ndone); else passes++;
    checks++; if (cipher_text !== 64'h0) $display("FAIL mid_rst_ct_hold: got %h want 0", cipher_text); else passes++;
    pt = {$urandom, $urandom}; key = {$urandom, $urandom};
    run_block(pt, key, ct, lat);
    checks++; if (ct !== ref_des(pt, key)) $display("FAIL mid_rst_new_ct: got %h want %h", ct, ref_des(pt, key)); else passes++;
    checks++; if (lat !== 17) $display("FAIL mid_rst_new_lat: got %0d want 17", lat); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a_pt, a_key, b_pt, b_key;
    int lat, gap;
    a_pt = {$urandom, $urandom}; a_key = {$urandom, $urandom};
    b_pt = {$urandom, $urandom}; b_key = {$urandom, $urandom};
    @(negedge clk); plain_text = a_pt; cipher_key = a_key; start = 1'b1;
    @(posedge clk); #1;
    plain_text = b_pt; cipher_key = b_key;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 17) $display("FAIL b2b_first_lat: got %0d want 17", lat); else passes++;
    checks++; if (cipher_text !== ref_des(a_pt, a_key)) $display("FAIL b2b_first_ct: got %h want %h", cipher_text, ref_des(a_pt, a_key)); else passes++;
    @(posedge clk); #1;
    start = 1'b0;
    gap = 1;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    checks++; if (gap !== 17) $display("FAIL b2b_gap: got %0d want 17", gap); else passes++;
    checks++; if (cipher_text !== ref_des(b_pt, b_key)) $display("FAIL b2b_second_ct: got %h want %h", cipher_text, ref_des(b_pt, b_key)); else passes++;
  endtask

  task automatic test_random();
    logic [63:0] ct, pt, key;
    int lat;
    for (int n = 0; n < 8; n++) begin
      pt = {$urandom, $urandom}; key = {$urandom, $urandom};
      run_block(pt, key, ct, lat);
      checks++; if (ct !== ref_des(pt, key)) $display("FAIL rand_ct[%0d]: got %h want %h", n, ct, ref_des(pt, key)); else passes++;
      checks++; if (lat !== 17) $display("FAIL rand_lat[%0d]: got %0d want 17", n, lat); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_kat();
    test_parity();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++; if (overlap_cnt !== 0) $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap_cnt); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
